// File: rtl/debounce_pkg.sv
// Shared types and constants for the debouncer and its synchronizer.
//
// Contents:
//   db_state_t   - two-state qualification FSM encoding
//   SYNC_STAGES  - depth of the optional input synchronizer
//   cnt_width()  - width of the qualification counter for a given window
package debounce_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } db_state_t;

    localparam int SYNC_STAGES = 2;

    // Counter width for a window of n samples. The counter only ever holds
    // 0..n-1, so $clog2(n) bits suffice; clamp to 1 so the width is never 0.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
//
// Ports:
//   clk    - destination clock
//   reset  - asynchronous active-low reset; all stages load RESET_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output, SYNC_STAGES clocks behind d_i
//
// Parameters:
//   RESET_VAL - value held in every stage during reset
module sync_2ff
    import debounce_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    // sync_p[0] may go metastable; later stages give it time to settle.
    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer for a raw single-bit input (button/switch).
//
// The committed level a_o only moves after the sample has differed from it
// for STABLE_CYCLES consecutive clocks; any shorter excursion is discarded
// and a single bounce restarts qualification from zero.
//
// Ports:
//   clk     - system clock, all state updates on posedge
//   reset   - asynchronous active-low reset, synchronous deassertion
//   a_i     - raw input (synchronous to clk unless DEBOUNCE_SYNC_EN)
//   a_o     - debounced level
//   busy_o  - high while a candidate level change is being qualified
//
// Parameters:
//   STABLE_CYCLES - consecutive differing samples to commit (2..65535)
//   RESET_VAL     - a_o / committed level during reset
//
// Build option:
//   DEBOUNCE_SYNC_EN - when defined, a_i passes through a 2-flop
//                      synchronizer first (adds 2 clocks of latency) and
//                      may be fully asynchronous.
module debouncer
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a_i,
    output logic a_o,
    output logic busy_o
);

    localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic s;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff #(
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_i),
        .q_o   (s)
    );
`else
    assign s = a_i;
`endif

    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // cnt counts differing samples seen so far in the current qualification;
    // the sample that brings it to STABLE_CYCLES commits instead of counting,
    // so cnt never exceeds STABLE_CYCLES-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= STABLE;
            cnt    <= '0;
            a_o    <= RESET_VAL;
            busy_o <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (s != a_o) begin
                        state  <= QUALIFY;
                        cnt    <= CNT_ONE;
                        busy_o <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end
                end
                QUALIFY: begin
                    if (s == a_o) begin
                        // Bounce back: no partial credit is kept.
                        state  <= STABLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        a_o    <= s;
                        state  <= STABLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= STABLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (STABLE_CYCLES=4, RESET_VAL=0).
// Directed scenarios with literal expectations, then randomized input,
// with every cycle compared against a window-based reference model.
module tb_debouncer;

    localparam int   N  = 4;
    localparam logic RV = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int LAT       = N + SD;
    localparam int BUSY_EDGE = 1 + SD;

    logic clk = 1'b0;
    logic reset;
    logic a_i;
    logic a_o;
    logic busy_o;

    always #5 clk = ~clk;

    debouncer #(
        .STABLE_CYCLES (N),
        .RESET_VAL     (RV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_i    (a_i),
        .a_o    (a_o),
        .busy_o (busy_o)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: the output moves to s once the last N samples taken
    // since reset all differ from the current output; busy is simply
    // "latest sample differs from the output".
    logic m_ao;
    logic m_busy;
    bit   hist[$];
    logic m_q0, m_q1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ao   = RV;
        m_busy = 1'b0;
        hist.delete();
        m_q0   = RV;
        m_q1   = RV;
    endtask

    task automatic model_edge();
        logic s;
        bit   all_diff;
        if (!reset) return;
`ifdef DEBOUNCE_SYNC_EN
        s    = m_q1;
        m_q1 = m_q0;
        m_q0 = a_i;
`else
        s = a_i;
`endif
        hist.push_back(bit'(s));
        if (hist.size() > N) void'(hist.pop_front());
        if (hist.size() == N) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_ao) all_diff = 1'b0;
            if (all_diff) m_ao = s;
        end
        m_busy = (s != m_ao);
    endtask

    // Drive v, let one posedge sample it, return 1 unit after the edge.
    task automatic step(input logic v);
        a_i = v;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Per-cycle compare against the model, plus minimum hold-time tracking.
    logic prev_ao;
    int   hold_cnt   = 0;
    bit   hold_valid = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_a_o", a_o, m_ao);
            check("model_busy_o", busy_o, m_busy);
            if (!reset) begin
                hold_valid = 1'b0;
                hold_cnt   = 0;
            end else if (a_o !== prev_ao) begin
                if (hold_valid) begin
                    checks++;
                    if (hold_cnt < N) begin
                        errors++;
                        $display("FAIL min_hold: held %0d cycles, required at least %0d", hold_cnt, N);
                    end
                end
                hold_valid = 1'b1;
                hold_cnt   = 1;
            end else begin
                hold_cnt++;
            end
            prev_ao = a_o;
        end
    end

    logic pat_restart [0:9];
    int   run;
    logic rv;

    initial begin
        reset = 1'b0;
        a_i   = 1'b1;
        model_reset();

        // Reset held with a_i=1: outputs stay at reset values.
        for (int e = 0; e < 2; e++) begin
            step(1'b1);
            check("reset_a_o", a_o, 1'b0);
            check("reset_busy_o", busy_o, 1'b0);
        end
        prev_ao = a_o;
        cmp_en  = 1'b1;

        // Release with a_i=1: a normal change, full latency.
        reset = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            step(1'b1);
            check("release_a_o", a_o, (e >= LAT) ? 1 : 0);
        end

        // Clean rise.
        hold(1'b0, LAT + 2);
        check("settle_low_a_o", a_o, 1'b0);
        for (int e = 1; e <= LAT; e++) begin
            step(1'b1);
            check("rise_busy_o", busy_o, (e >= BUSY_EDGE && e < LAT) ? 1 : 0);
            check("rise_a_o", a_o, (e >= LAT) ? 1 : 0);
        end

        // Bounce reject: three samples high, then low.
        hold(1'b0, LAT + 2);
        for (int e = 1; e <= 8; e++) begin
            step((e <= 3) ? 1'b1 : 1'b0);
            check("reject_a_o", a_o, 1'b0);
            if (e == 3 + SD) check("reject_busy_hi", busy_o, 1'b1);
            if (e == 4 + SD) check("reject_busy_lo", busy_o, 1'b0);
        end

        // Bounce restart: 1,1,0,1,1,1,1 -> rises only on the 7th edge.
        pat_restart = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int e = 1; e <= 7 + SD; e++) begin
            step(pat_restart[e-1]);
            check("restart_a_o", a_o, (e >= 7 + SD) ? 1 : 0);
        end

        // Mid-qualify reset from a_o=1: async clear of both outputs.
        hold(1'b1, 2);
        hold(1'b0, 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_a_o", a_o, 1'b0);
        check("async_rst_busy_o", busy_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Mid-qualify reset from a_o=0 with busy high, then requalify.
        hold(1'b0, LAT + 2);
        hold(1'b1, 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midq_rst_a_o", a_o, 1'b0);
        check("midq_rst_busy_o", busy_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            step(1'b1);
            check("midq_requal_a_o", a_o, (e >= LAT) ? 1 : 0);
        end

        // Random single-sample noise.
        for (int i = 0; i < 200; i++) step(logic'($urandom % 2));

        // Random runs, long enough to commit some of the time.
        for (int i = 0; i < 60; i++) begin
            rv  = logic'($urandom % 2);
            run = $urandom_range(1, 2 * LAT);
            hold(rv, run);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Conditions a raw, bouncy single-bit input (button or switch) into a clean level for the downstream edge_detector's a_i.
- Holds a committed output level and updates it only after the input has stayed at the opposite level for STABLE_CYCLES consecutive clocks.
- Glitches shorter than that window are discarded.

Parameters:
- STABLE_CYCLES, 4: consecutive differing samples required to commit a new level. Legal range is 2..65535.
- RESET_VAL, 1'b0: value of a_o and the committed level during reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- a_i  input  1  raw input; may be asynchronous to clk only when DEBOUNCE_SYNC_EN is defined.
- a_o  output  1  debounced level; feeds edge_detector a_i.
- busy_o  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (reset==0): state=STABLE, cnt=0, a_o=RESET_VAL, busy_o=0. Takes effect immediately, independent of clk. Any qualification in progress is abandoned.
- Internal sample s: equals a_i directly, or the synchronizer output when DEBOUNCE_SYNC_EN is defined.
- Counter cnt: width $clog2(STABLE_CYCLES), unsigned. It never exceeds STABLE_CYCLES-1, so no wrap is possible.
- FSM, two states:
  - STABLE:
    - If s==a_o: stay, cnt=0.
    - If s!=a_o: go to QUALIFY, cnt<=1.
  - QUALIFY:
    - If s==a_o (bounce back): go to STABLE, cnt<=0, a_o unchanged.
    - If s!=a_o and cnt==STABLE_CYCLES-1: a_o<=s, cnt<=0, go to STABLE.
    - If s!=a_o otherwise: cnt<=cnt+1.
- busy_o is registered and equals (state==QUALIFY).
- Latency without sync: first differing sample is at posedge k. a_o changes on posedge k+STABLE_CYCLES-1 if s held through that edge, i.e. exactly STABLE_CYCLES sampling edges inclusive.
- Pulse rejection: a_i differing for STABLE_CYCLES-1 or fewer sampled edges never alters a_o.
- A glitch of one sample during QUALIFY restarts qualification from zero. There is no partial credit.
- a_o toggles at most once per STABLE_CYCLES clocks. Consequently edge_detector pulses are separated by at least STABLE_CYCLES cycles.
- Reset release with a_i != RESET_VAL: treated as a normal change. a_o follows after the full latency.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: a_i passes through a 2-flop synchronizer, reset to RESET_VAL, before s. Total latency is STABLE_CYCLES+2 edges from the first edge that captures the new a_i. a_i may be fully asynchronous.
- Not defined: s=a_i and latency is as stated above. a_i must be synchronous to clk.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic {STABLE, QUALIFY} db_state_t
  - localparam SYNC_STAGES=2
- Sub-module sync_2ff (clk, reset, d_i, q_o, RESET_VAL parameter). Instantiated only under DEBOUNCE_SYNC_EN; reusable elsewhere.
- Top holds the FSM and counter, roughly 150 lines total.

Test Plan:
All scenarios use STABLE_CYCLES=4, RESET_VAL=0, macro undefined unless noted. Stimulus changes 1 time unit after posedge.
- Reset: hold reset=0 for 2 clocks with a_i=1 -> a_o=0, busy_o=0 throughout. After release, a_o=1 exactly 4 posedges later.
- Clean rise: a_i 0->1 and held -> busy_o=1 after the 1st edge; a_o=1 after the 4th edge; busy_o=0 after the 4th edge.
- Bounce reject: a_i=1 for 3 edges, then 0 -> a_o stays 0; busy_o returns to 0 on the edge sampling 0.
- Bounce restart: a_i pattern 1,1,0,1,1,1,1 (one value per edge) -> a_o rises only after the 7th edge.
- Mid-qualify reset: a_i=1 for 2 edges, then reset asserted between edges -> a_o=0 and busy_o=0 immediately (asynchronous). cnt restarts after release.
- Macro build: define DEBOUNCE_SYNC_EN and apply a clean rise -> a_o=1 after the 6th edge. Check with 200 random a_i values ($urandom%2) that a_o never holds a new value for fewer than 4 cycles.
